// File: rtl/full_adder_core_if.sv
// full_adder_core_if: operand/result bundle; master drives a/b/c_in/in_valid and receives s/c_out/out_valid, slave is the adder side
interface full_adder_core_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             out_valid;
  modport master (output a, b, c_in, in_valid, input s, c_out, out_valid);
  modport slave  (input a, b, c_in, in_valid, output s, c_out, out_valid);
endinterface

// File: rtl/full_adder_core.sv
// full_adder_core: registered WIDTH-bit ripple-carry add with carry-in; ports clk, rst_n (async active-low), bus (a, b, c_in, in_valid -> s, c_out, out_valid one cycle later)
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  full_adder_core_if.slave    bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;
  assign c[0] = bus.c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum[i]  = bus.a[i] ^ bus.b[i] ^ c[i];
    assign c[i+1]  = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
  end
  // result registers load only on accepted input, so idle-cycle X/Z on operands never reaches them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.s         <= '0;
      bus.c_out     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s     <= sum;
        bus.c_out <= c[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: scoreboard bench for full_adder_core at WIDTH=1 and WIDTH=8
module tb_full_adder_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] q1[$];
  logic [8:0] q8[$];
  full_adder_core_if #(.WIDTH(1)) i1 ();
  full_adder_core_if #(.WIDTH(8)) i8 ();
  full_adder_core #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  full_adder_core #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic step1(input logic a, input logic b, input logic c, input logic v, input logic [1:0] e);
    i1.a = a; i1.b = b; i1.c_in = c; i1.in_valid = v;
    if (v) q1.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v, input logic [8:0] e);
    i8.a = a; i8.b = b; i8.c_in = c; i8.in_valid = v;
    if (v) q8.push_back(e);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (i1.out_valid) begin
      if (q1.size() == 0) chk("w1_unexpected_out", 1, 0);
      else chk("w1_result", {i1.c_out, i1.s}, q1.pop_front());
    end
    if (i8.out_valid) begin
      if (q8.size() == 0) chk("w8_unexpected_out", 1, 0);
      else chk("w8_result", {i8.c_out, i8.s}, q8.pop_front());
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] ra, rb;
    logic rc;
    i1.a = 0; i1.b = 0; i1.c_in = 0; i1.in_valid = 0;
    i8.a = 0; i8.b = 0; i8.c_in = 0; i8.in_valid = 0;
    for (int k = 0; k < 3; k++) begin
      i1.a = 1'($urandom); i1.b = 1'($urandom); i1.c_in = 1'($urandom); i1.in_valid = 1'b1;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.c_in = 1'($urandom); i8.in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_w1", {i1.out_valid, i1.c_out, i1.s}, 0);
      chk("rst_hold_w8", {i8.out_valid, i8.c_out, i8.s}, 0);
    end
    i1.in_valid = 0; i8.in_valid = 0;
    rst_n = 1'b1;
    step1(0, 0, 0, 1, 2'b00);
    step1(0, 0, 1, 1, 2'b01);
    step1(1, 0, 0, 1, 2'b01);
    step1(1, 0, 1, 1, 2'b10);
    step1(0, 1, 0, 1, 2'b01);
    step1(1, 1, 1, 1, 2'b11);
    step1(1, 1, 0, 1, 2'b10);
    chk("w1_latency", {i1.out_valid, i1.c_out, i1.s}, 3'b110);
    step1(0, 0, 1, 0, 2'b00);
    chk("w1_hold", {i1.out_valid, i1.c_out, i1.s}, 3'b010);
    step1(1, 0, 1, 0, 2'b00);
    chk("w1_hold2", {i1.out_valid, i1.c_out, i1.s}, 3'b010);
    step8(8'hFF, 8'h00, 1, 1, 9'h100);
    step8(8'hFF, 8'hFF, 1, 1, 9'h1FF);
    step8(8'h0F, 8'hF0, 0, 1, 9'h0FF);
    step8('x, 'x, 1'bx, 0, 9'h000);
    step8('x, 'x, 1'bx, 0, 9'h000);
    chk("w8_hold_x", {i8.out_valid, i8.c_out, i8.s}, 10'h0FF);
    step8(8'd10, 8'd20, 0, 1, 9'd30);
    i8.a = 8'd1; i8.b = 8'd2; i8.c_in = 1'b0; i8.in_valid = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_clear_w8", {i8.out_valid, i8.c_out, i8.s}, 0);
    chk("async_clear_w1", {i1.out_valid, i1.c_out, i1.s}, 0);
    @(posedge clk);
    #1;
    chk("rst_discard_w8", {i8.out_valid, i8.c_out, i8.s}, 0);
    rst_n = 1'b1;
    step8(8'd100, 8'd200, 1, 1, 9'h12D);
    chk("post_rst_latency", {i8.out_valid, i8.c_out, i8.s}, 10'h32D);
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      step8(ra, rb, rc, 1, 9'(ra) + 9'(rb) + 9'(rc));
    end
    step8(0, 0, 0, 0, 9'h000);
    step8(0, 0, 0, 0, 9'h000);
    chk("w8_idle_valid", i8.out_valid, 0);
    chk("w1_queue_drained", q1.size(), 0);
    chk("w8_queue_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
